// File: rtl/execute_pipe.sv
// ----------------------------------------------------------------------------
// execute_pipe
//
// Registered execute stage of the WISC pipeline. One decoded instruction is
// taken per cycle over a valid/ready handshake. The stage computes the ALU
// result, memory address or branch target and holds it in the EX/MEM output
// register. It owns the {Z, V, N} flag register and resolves conditional
// branches against the registered flags.
//
// Parameters
//   DW   datapath width (multiple of 8, >= 16)
//   SHW  shift-amount width, taken from imm[SHW-1:0]
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake
//   instr             opcode [15:12], condition code [11:9]
//   imm               sign-extended immediate
//   alu_src           1: operand B = imm, 0: operand B = rdata2
//   rdata1, rdata2    register operands A and B
//   pc_inc            PC + 2 of this instruction
//   flush             kill output register contents
//   out_valid/out_ready downstream handshake
//   out_result        ALU result, memory address or pc_inc (PCS)
//   out_instr         instruction carried with the result
//   br_taken, br_dest branch resolution
//   flags             {Z, V, N}
//   halted            HLT has been accepted (sticky until reset)
// ----------------------------------------------------------------------------
module execute_pipe #(
    parameter int DW  = 16,
    parameter int SHW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   instr,
    input  logic [DW-1:0] imm,
    input  logic          alu_src,
    input  logic [DW-1:0] rdata1,
    input  logic [DW-1:0] rdata2,
    input  logic [DW-1:0] pc_inc,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [15:0]   out_instr,
    output logic          br_taken,
    output logic [DW-1:0] br_dest,
    output logic [2:0]    flags,
    output logic          halted
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_RED    = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LHB    = 4'b1010;
    localparam logic [3:0] OP_LLB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    // Saturating add/subtract; returns {overflow, result}.
    function automatic logic [DW:0] sat_addsub(input logic signed [DW-1:0] a,
                                               input logic signed [DW-1:0] b,
                                               input logic sub);
        logic signed [DW:0] s;
        logic [DW:0]        r;
        if (sub) s = {a[DW-1], a} - {b[DW-1], b};
        else     s = {a[DW-1], a} + {b[DW-1], b};
        // Overflow when the extra sign bit disagrees with the result MSB.
        if (s[DW] != s[DW-1]) r = {1'b1, (s[DW] ? SAT_MIN : SAT_MAX)};
        else                  r = {1'b0, s[DW-1:0]};
        return r;
    endfunction

    // Sum of all bytes of a and b as signed 8-bit values. The accumulator
    // cannot overflow for DW >= 16, so the DW-wide sum is already the
    // sign-extended result.
    function automatic logic [DW-1:0] red_sum(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic signed [DW-1:0] acc;
        acc = '0;
        for (int i = 0; i < DW/8; i++) begin
            acc = acc + {{(DW-8){a[8*i+7]}}, a[8*i +: 8]};
            acc = acc + {{(DW-8){b[8*i+7]}}, b[8*i +: 8]};
        end
        return acc;
    endfunction

    // Independent 4-bit signed saturating lanes.
    function automatic logic [DW-1:0] paddsb(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [DW-1:0]     r;
        logic signed [4:0] s;
        r = '0;
        for (int i = 0; i < DW/4; i++) begin
            s = {a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]};
            if (s[4] != s[3]) r[4*i +: 4] = s[4] ? 4'b1000 : 4'b0111;
            else              r[4*i +: 4] = s[3:0];
        end
        return r;
    endfunction

    // Branch condition evaluation against {Z, V, N}.
    function automatic logic cond_met(input logic [2:0] ccc,
                                      input logic z, input logic v,
                                      input logic n);
        logic c;
        case (ccc)
            3'b000:  c = ~z;
            3'b001:  c = z;
            3'b010:  c = ~z & ~n;
            3'b011:  c = n;
            3'b100:  c = z | ~(z | n);
            3'b101:  c = n | z;
            3'b110:  c = v;
            default: c = 1'b1;
        endcase
        return c;
    endfunction

    logic                 out_valid_q, out_valid_d;
    logic [DW-1:0]        out_result_q, out_result_d;
    logic [15:0]          out_instr_q, out_instr_d;
    logic                 br_taken_q, br_taken_d;
    logic [DW-1:0]        br_dest_q, br_dest_d;
    logic [2:0]           flags_q, flags_d;
    logic                 halted_q, halted_d;

    logic [3:0]           opcode;
    logic [2:0]           ccc;
    logic signed [DW-1:0] op_a;
    logic signed [DW-1:0] op_b;
    logic [SHW-1:0]       shamt;
    logic [2*DW-1:0]      ror_wide;
    logic [DW:0]          addsub;
    logic [DW-1:0]        ex_result;
    logic [2:0]           ex_flags;
    logic                 ex_br_taken;
    logic [DW-1:0]        ex_br_dest;
    logic                 accept;

    assign opcode   = instr[15:12];
    assign ccc      = instr[11:9];
    assign op_a     = rdata1;
    assign op_b     = alu_src ? imm : rdata2;
    assign shamt    = imm[SHW-1:0];
    assign ror_wide = {rdata1, rdata1} >> shamt;
    assign addsub   = sat_addsub(op_a, op_b, opcode == OP_SUB);

    assign in_ready = ~halted_q & (~out_valid_q | out_ready);
    // A flush in the same cycle drops the presented instruction entirely.
    assign accept   = in_valid & in_ready & ~flush;

    // Execute: combinational result, flags and branch resolution.
    always_comb begin
        ex_result   = '0;
        ex_flags    = flags_q;
        ex_br_taken = 1'b0;
        ex_br_dest  = '0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                ex_result = addsub[DW-1:0];
                ex_flags  = {(addsub[DW-1:0] == '0), addsub[DW], addsub[DW-1]};
            end
            OP_RED:    ex_result = red_sum(rdata1, op_b);
            OP_XOR:    ex_result = rdata1 ^ op_b;
            OP_SLL:    ex_result = rdata1 << shamt;
            OP_SRA:    ex_result = op_a >>> shamt;
            OP_ROR:    ex_result = ror_wide[DW-1:0];
            OP_PADDSB: ex_result = paddsb(rdata1, op_b);
            OP_LW, OP_SW: ex_result = rdata1 + (imm << 1);
            OP_LHB:    ex_result = {imm[DW/2-1:0], rdata1[DW/2-1:0]};
            OP_LLB:    ex_result = {rdata1[DW-1:DW/2], imm[DW/2-1:0]};
            OP_B: begin
                ex_br_dest  = pc_inc + (imm << 1);
                ex_br_taken = cond_met(ccc, flags_q[2], flags_q[1], flags_q[0]);
            end
            OP_BR: begin
                ex_br_dest  = rdata1;
                ex_br_taken = cond_met(ccc, flags_q[2], flags_q[1], flags_q[0]);
            end
            OP_PCS:    ex_result = pc_inc;
            default:   ex_result = '0;
        endcase
        // Logic/shift/vector ops touch Z only; V and N hold.
        if (opcode inside {OP_RED, OP_XOR, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB})
            ex_flags[2] = (ex_result == '0);
    end

    // Output register, flag register and halt next-state.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_instr_d  = out_instr_q;
        br_taken_d   = br_taken_q;
        br_dest_d    = br_dest_q;
        flags_d      = flags_q;
        halted_d     = halted_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_result_d = ex_result;
            out_instr_d  = instr;
            br_taken_d   = ex_br_taken;
            br_dest_d    = ex_br_dest;
            flags_d      = ex_flags;
            if (opcode == OP_HLT) halted_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_instr_q  <= '0;
            br_taken_q   <= 1'b0;
            br_dest_q    <= '0;
            flags_q      <= 3'b000;
            halted_q     <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_instr_q  <= out_instr_d;
            br_taken_q   <= br_taken_d;
            br_dest_q    <= br_dest_d;
            flags_q      <= flags_d;
            halted_q     <= halted_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_instr  = out_instr_q;
    assign br_taken   = br_taken_q;
    assign br_dest    = br_dest_q;
    assign flags      = flags_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_execute_pipe.sv
// ----------------------------------------------------------------------------
// tb_execute_pipe
//
// Directed-vector bench for execute_pipe (DW=16). Expected values are
// hand-computed constants; flags are written as {Z, V, N}.
// ----------------------------------------------------------------------------
module tb_execute_pipe;

    localparam int DW = 16;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, RED = 4'h2, XOR_ = 4'h3;
    localparam logic [3:0] SLL = 4'h4, SRA = 4'h5, ROR = 4'h6, PADDSB = 4'h7;
    localparam logic [3:0] LW = 4'h8, LHB = 4'hA, LLB = 4'hB;
    localparam logic [3:0] BR_ = 4'hC, BRR = 4'hD, PCS = 4'hE, HLT = 4'hF;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   instr;
    logic [DW-1:0] imm;
    logic          alu_src;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic [DW-1:0] pc_inc;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [15:0]   out_instr;
    logic          br_taken;
    logic [DW-1:0] br_dest;
    logic [2:0]    flags;
    logic          halted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    execute_pipe #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .imm        (imm),
        .alu_src    (alu_src),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .pc_inc     (pc_inc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_instr  (out_instr),
        .br_taken   (br_taken),
        .br_dest    (br_dest),
        .flags      (flags),
        .halted     (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] cc,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] im, input logic src,
                         input logic [15:0] pc);
        in_valid = 1'b1;
        instr    = {op, cc, 9'b0};
        rdata1   = a;
        rdata2   = b;
        imm      = im;
        alu_src  = src;
        pc_inc   = pc;
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] cc,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] im, input logic src,
                        input logic [15:0] pc);
        drive(op, cc, a, b, im, src, pc);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; instr = '0; imm = '0; alu_src = 1'b0;
        rdata1 = '0; rdata2 = '0; pc_inc = '0; flush = 1'b0; out_ready = 1'b1;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_br_taken", br_taken, 0);
        check("rst_br_dest", br_dest, 0);
        check("rst_flags", flags, 0);
        check("rst_halted", halted, 0);
        rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Saturation and flag updates
        send(ADD, 3'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 16'h0);
        check("add_valid", out_valid, 1);
        check("add_sat_pos", out_result, 16'h7FFF);
        check("add_flags", flags, 3'b010);
        send(SUB, 3'd0, 16'h8000, 16'h0001, 16'h0000, 1'b0, 16'h0);
        check("sub_sat_neg", out_result, 16'h8000);
        check("sub_flags", flags, 3'b011);
        send(PADDSB, 3'd0, 16'h7777, 16'h1111, 16'h0000, 1'b0, 16'h0);
        check("paddsb", out_result, 16'h7777);
        check("paddsb_flags", flags, 3'b011);
        send(XOR_, 3'd0, 16'h00FF, 16'h00FF, 16'h0000, 1'b0, 16'h0);
        check("xor", out_result, 16'h0000);
        check("xor_flags", flags, 3'b111);
        send(SUB, 3'd0, 16'h0005, 16'h0005, 16'h0000, 1'b0, 16'h0);
        check("sub_zero", out_result, 16'h0000);
        check("sub_zero_flags", flags, 3'b100);

        // Branches against the registered flags
        send(BR_, 3'b001, 16'h0, 16'h0, 16'h0004, 1'b1, 16'h0010);
        check("b_eq_taken", br_taken, 1);
        check("b_eq_dest", br_dest, 16'h0018);
        check("b_instr", out_instr, 16'hC200);
        send(BR_, 3'b000, 16'h0, 16'h0, 16'h0004, 1'b1, 16'h0010);
        check("b_ne_taken", br_taken, 0);
        check("b_flags_hold", flags, 3'b100);
        send(BRR, 3'b111, 16'h1234, 16'h0, 16'h0, 1'b0, 16'h0);
        check("br_taken", br_taken, 1);
        check("br_dest", br_dest, 16'h1234);

        // Remaining datapath operations
        send(RED, 3'd0, 16'hFF01, 16'h8003, 16'h0, 1'b0, 16'h0);
        check("red", out_result, 16'hFF83);
        check("red_flags", flags, 3'b000);
        check("red_no_branch", br_taken, 0);
        send(SLL, 3'd0, 16'h0003, 16'h0, 16'h0004, 1'b1, 16'h0);
        check("sll", out_result, 16'h0030);
        send(SRA, 3'd0, 16'h8000, 16'h0, 16'h0004, 1'b1, 16'h0);
        check("sra", out_result, 16'hF800);
        send(ROR, 3'd0, 16'h1234, 16'h0, 16'h0004, 1'b1, 16'h0);
        check("ror", out_result, 16'h4123);
        send(LW, 3'd0, 16'hFFFF, 16'h0, 16'h0001, 1'b1, 16'h0);
        check("lw_wrap", out_result, 16'h0001);
        send(LHB, 3'd0, 16'h1234, 16'h0, 16'h00AB, 1'b1, 16'h0);
        check("lhb", out_result, 16'hAB34);
        send(LLB, 3'd0, 16'h1234, 16'h0, 16'hFFCD, 1'b1, 16'h0);
        check("llb", out_result, 16'h12CD);
        send(PCS, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0042);
        check("pcs", out_result, 16'h0042);
        check("pcs_flags", flags, 3'b000);
        send(ADD, 3'd0, 16'h8000, 16'hFFFF, 16'h0, 1'b0, 16'h0);
        check("add_sat_neg", out_result, 16'h8000);
        check("add_neg_flags", flags, 3'b011);

        // Stall: downstream not ready for three cycles
        out_ready = 1'b0;
        drive(ADD, 3'd0, 16'h0001, 16'h0002, 16'h0, 1'b0, 16'h0);
        #1;
        check("stall_in_ready0", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_result", out_result, 16'h8000);
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_flags", flags, 3'b011);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        tick();
        check("release_result", out_result, 16'h0003);
        check("release_flags", flags, 3'b000);

        // Flush drops a same-cycle acceptance
        drive(ADD, 3'd0, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 16'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_flags", flags, 3'b000);

        send(SUB, 3'd0, 16'h0000, 16'h0001, 16'h0, 1'b0, 16'h0);
        check("sub_neg", out_result, 16'hFFFF);
        check("sub_neg_flags", flags, 3'b001);

        // Halt, then asynchronous reset while stalled
        send(HLT, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);
        check("hlt_halted", halted, 1);
        check("hlt_in_ready", in_ready, 0);
        check("hlt_instr", out_instr, 16'hF000);
        out_ready = 1'b0;
        tick();
        check("hlt_stall_valid", out_valid, 1);
        check("hlt_still_halted", halted, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_instr", out_instr, 0);
        check("arst_flags", flags, 0);
        check("arst_halted", halted, 0);
        check("arst_br_dest", br_dest, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
